serial_tx_shifter: RTL and testbench

Parallel-to-serial front end for the Mealy sequence detector: accepts `WIDTH`-bit words over a valid/ready handshake and drives them out one bit per clock on a single serial line, which connects directly to the detector's `in` port. A one-entry holding register lets consecutive words stream with no idle bits between them. An `out_valid` qualifier and a `word_done` pulse mark the serial bit boundaries.

---
 rtl/serial_tx_shifter.sv | 119 +++++++++++
 tb/tb_serial_tx_shifter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter
// Parallel-to-serial front end. Takes WIDTH-bit words over valid/ready and
// drives them out one bit per clock. A one-entry holding register lets the
// next word be queued while the current one shifts, so words stream gapless.
// All serial outputs are decoded from flops only.

module serial_tx_shifter #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             word_done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] sh_next;

    // Ready only depends on the holding flag and reset, so a reload and an
    // accept can never land on the same edge.
    assign din_ready = !hold_full_q && !rst;
    assign accept    = din_valid && din_ready;
    assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    // Shift toward whichever end is transmitted.
    assign sh_next = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0}
                               : {1'b0, sh_q[WIDTH-1:1]};

    // Serial outputs come straight from state, shifter and counter flops.
    assign out_valid = (state_q == SHIFT);
    assign word_done = last_bit;
    assign out       = (state_q == SHIFT) ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0])
                                          : IDLE_BIT;

    // State register; reset discards any partial and any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: load/reload from the holding register, shift, and accept.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        // Gapless hand-off: next word starts on the very next bit.
                        sh_d        = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        sh_d    = sh_next;
                        state_d = IDLE;
                    end
                end else begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // hold_full is 0 whenever accept is possible, so this never
        // overrides a load/reload decided above.
        if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Bench for serial_tx_shifter: an MSB-first and an LSB-first instance share
// the same stimulus. A scoreboard queue gets the expected bits of each word
// when it is accepted; the monitor pops them as out_valid bits appear.

module tb_serial_tx_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       rdy_m, out_m, ov_m, wd_m;
    logic       rdy_l, out_l, ov_l, wd_l;

    int nchk  = 0;
    int nfail = 0;

    typedef struct {
        logic bm;
        logic bl;
        logic last;
    } sb_t;
    sb_t sbq[$];

    always #5 clk = ~clk;

    serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .out(out_m), .out_valid(ov_m), .word_done(wd_m)
    );

    serial_tx_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .out(out_l), .out_valid(ov_l), .word_done(wd_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare serial bits against the scoreboard, push new words.
    always @(negedge clk) begin
        sb_t e;
        chk("ov_lsb_eq_msb", {31'd0, ov_l}, {31'd0, ov_m});
        chk("rdy_lsb_eq_msb", {31'd0, rdy_l}, {31'd0, rdy_m});
        if (ov_m) begin
            chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("bit_msb", {31'd0, out_m}, {31'd0, e.bm});
                chk("bit_lsb", {31'd0, out_l}, {31'd0, e.bl});
                chk("wd_msb", {31'd0, wd_m}, {31'd0, e.last});
                chk("wd_lsb", {31'd0, wd_l}, {31'd0, e.last});
            end
        end else begin
            chk("idle_out", {30'd0, out_m, out_l}, 32'd0);
            chk("idle_wd", {30'd0, wd_m, wd_l}, 32'd0);
        end
        if (rst) begin
            chk("rst_ready", {31'd0, rdy_m}, 32'd0);
            sbq.delete();
        end else if (din_valid && rdy_m) begin
            for (int k = 0; k < 8; k++) begin
                e.bm   = din[7-k];
                e.bl   = din[k];
                e.last = (k == 7);
                sbq.push_back(e);
            end
        end
    end

    // Present n words back to back with din_valid held high. Call just after
    // a posedge. Edge indices are relative to the first accept edge E0.
    task automatic stream(input int n, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2);
        logic [7:0] w [3];
        int   idx;
        int   p;
        logic acc;
        w[0] = w0; w[1] = w1; w[2] = w2;
        idx = 0;
        din = w[0];
        din_valid = 1'b1;
        for (int c = 0; c <= 8 * n + 2; c++) begin
            @(negedge clk);
            if (c > 0) begin
                p = c - 1;  // this is the cycle after E(p)
                chk($sformatf("ov_n%0d_c%0d", n, p), {31'd0, ov_m},
                    {31'd0, (p >= 1 && p <= 8 * n)});
                chk($sformatf("wd_n%0d_c%0d", n, p), {31'd0, wd_m},
                    {31'd0, (p >= 8 && p <= 8 * n && p % 8 == 0)});
                if (n == 3 && p >= 2 && p <= 9)
                    chk($sformatf("bp_ready_c%0d", p), {31'd0, rdy_m}, {31'd0, p == 9});
            end
            acc = din_valid && rdy_m;
            if (acc) begin
                chk($sformatf("accept_edge_w%0d", idx), c, (idx == 0) ? 0 : 8 * (idx - 1) + 2);
                idx++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (idx < n) din = w[idx];
                else begin
                    din_valid = 1'b0;
                    din = '0;
                end
            end
        end
        chk($sformatf("words_taken_n%0d", n), idx, n);
    endtask

    initial begin
        rst = 1'b1;
        din = 8'h55;
        din_valid = 1'b1;

        // Reset with a word offered: nothing accepted, outputs idle.
        repeat (2) begin
            @(negedge clk);
            chk("rst_out", {29'd0, out_m, ov_m, wd_m}, 32'd0);
            chk("rst_rdy", {31'd0, rdy_m}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        din_valid = 1'b0;
        din = '0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, rdy_m}, 32'd1);
        chk("ov_after_rst", {31'd0, ov_m}, 32'd0);
        @(posedge clk); #1;

        // Single word, back-to-back pair, three words under backpressure.
        stream(1, 8'hB4, 8'h00, 8'h00);
        stream(2, 8'hD0, 8'h0F, 8'h00);
        stream(3, 8'h3C, 8'hA5, 8'h96);

        // Reset in the middle of 8'hFF with 8'hAA pending.
        din = 8'hFF;
        din_valid = 1'b1;
        @(posedge clk); #1;   // E0: FF accepted
        din = 8'hAA;
        @(posedge clk); #1;   // E1: FF loaded
        @(posedge clk); #1;   // E2: AA accepted
        din_valid = 1'b0;
        din = '0;
        @(negedge clk);
        chk("mid_aa_held", {31'd0, rdy_m}, 32'd0);
        @(posedge clk); #1;   // E3
        rst = 1'b1;
        @(negedge clk);
        chk("mid_bit2_valid", {30'd0, ov_m, out_m}, 32'd3);
        @(posedge clk); #1;   // E4: reset edge
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_rst", {29'd0, out_m, ov_m, wd_m}, 32'd0);
        chk("mid_post_rdy", {31'd0, rdy_m}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("aa_discarded_%0d", i), {31'd0, ov_m}, 32'd0);
        end
        @(posedge clk); #1;
        stream(1, 8'h81, 8'h00, 8'h00);

        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
